// File: rtl/spi_read_adc_if.sv
// Handshake and serial-bus bundle between the ADC read sequencer (master)
// and the spi_read_adc block (slave).
interface spi_read_adc_if #(
  parameter int DATA_W = 12,
  parameter int KW     = 8
);
  logic              strr_i;
  logic [KW-1:0]     kmax_i;
  logic              miso_i;
  logic              cs_o;
  logic              dclk_o;
  logic [DATA_W-1:0] data_o;
  logic              eor_o;
  logic              busy_o;

  modport slave (
    input  strr_i, kmax_i, miso_i,
    output cs_o, dclk_o, data_o, eor_o, busy_o
  );

  modport master (
    output strr_i, kmax_i, miso_i,
    input  cs_o, dclk_o, data_o, eor_o, busy_o
  );
endinterface

// File: rtl/spi_read_adc.sv
// SPI mode-0 read stage: on a start request it drops CS, clocks DATA_W bits in
// MSB first on rising dclk edges, then reports the word with a one-cycle eor pulse.
module spi_read_adc #(
  parameter int DATA_W = 12,
  parameter int KW     = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  spi_read_adc_if.slave bus
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [KW-1:0]     cnt_q, cnt_d;
  logic [KW-1:0]     kmax_q, kmax_d;
  logic [CW-1:0]     bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              cs_q, cs_d;
  logic              dclk_q, dclk_d;
  logic              eor_q, eor_d;
  logic              busy_q, busy_d;
  logic              tick_s;

  assign tick_s = (cnt_q == kmax_q);

  // Next-state, datapath and output decode; outputs follow the next state so they stay registered.
  always_comb begin
    state_d  = state_q;
    kmax_d   = kmax_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    eor_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.strr_i) begin
          kmax_d   = bus.kmax_i;
          bitcnt_d = {CW{1'b0}};
          shreg_d  = {DATA_W{1'b0}};
          state_d  = S_SETUP;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_SETUP: begin
        if (tick_s) begin
          shreg_d = {shreg_q[DATA_W-2:0], bus.miso_i};
          state_d = S_HIGH;
        end else begin
          state_d = S_SETUP;
        end
      end
      S_HIGH: begin
        if (tick_s) begin
          if (bitcnt_q == LAST_BIT) begin
            state_d  = S_HOLD;
          end else begin
            bitcnt_d = bitcnt_q + CW'(1);
            state_d  = S_LOW;
          end
        end else begin
          state_d = S_HIGH;
        end
      end
      S_LOW: begin
        if (tick_s) begin
          shreg_d = {shreg_q[DATA_W-2:0], bus.miso_i};
          state_d = S_HIGH;
        end else begin
          state_d = S_LOW;
        end
      end
      S_HOLD: begin
        if (tick_s) begin
          data_d  = shreg_q;
          eor_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The divider restarts on every state change so each half-period is full length.
    if ((state_d != state_q) || (state_q == S_IDLE)) begin
      cnt_d = {KW{1'b0}};
    end else if (tick_s) begin
      cnt_d = {KW{1'b0}};
    end else begin
      cnt_d = cnt_q + KW'(1);
    end

    cs_d   = (state_d == S_IDLE);
    dclk_d = (state_d == S_HIGH);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= {KW{1'b0}};
      kmax_q   <= {KW{1'b0}};
      bitcnt_q <= {CW{1'b0}};
      shreg_q  <= {DATA_W{1'b0}};
      data_q   <= {DATA_W{1'b0}};
      cs_q     <= 1'b1;
      dclk_q   <= 1'b0;
      eor_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      kmax_q   <= kmax_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      cs_q     <= cs_d;
      dclk_q   <= dclk_d;
      eor_q    <= eor_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.cs_o   = cs_q;
  assign bus.dclk_o = dclk_q;
  assign bus.data_o = data_q;
  assign bus.eor_o  = eor_q;
  assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_spi_read_adc.sv
// Directed bench for spi_read_adc with a mode-0 ADC model that shifts a word
// out MSB first, changing miso after each falling dclk edge.
module tb_spi_read_adc;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  spi_read_adc_if #(.DATA_W(12), .KW(8)) bus ();

  spi_read_adc #(.DATA_W(12), .KW(8)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADC model state
  logic [11:0] adc_words [0:1];
  int          word_base;
  int          frames_seen;
  logic [11:0] cur_word;
  int          idx;
  logic        prev_cs;
  logic        prev_dclk;

  initial begin
    frames_seen = 0;
    idx         = 0;
    cur_word    = 12'h000;
    prev_cs     = 1'b1;
    prev_dclk   = 1'b0;
    bus.miso_i  = 1'b0;
  end

  // CS fall loads the next word and presents its MSB; each dclk fall advances one bit.
  always @(posedge clk) begin
    #1;
    if (prev_cs && !bus.cs_o) begin
      cur_word = (frames_seen == word_base) ? adc_words[0] : adc_words[1];
      frames_seen = frames_seen + 1;
      idx = 11;
      bus.miso_i = cur_word[idx];
    end else if (prev_dclk && !bus.dclk_o) begin
      if (idx > 0) idx = idx - 1;
      bus.miso_i = cur_word[idx];
    end
    prev_cs   = bus.cs_o;
    prev_dclk = bus.dclk_o;
  end

  // Runs one frame from a strr pulse; optionally re-pulses strr with kmax=7 at sample poke_at.
  task automatic run_frame(input logic [7:0] k, input logic [11:0] w, input int poke_at,
                           output int eor_at, output int cs_low, output int rises,
                           output int hi_min, output int hi_max, output int eors,
                           output logic [11:0] dat, output logic busy0);
    int   hi_run;
    logic prev_d;
    @(negedge clk);
    word_base    = frames_seen;
    adc_words[0] = w;
    adc_words[1] = w;
    bus.kmax_i   = k;
    bus.strr_i   = 1'b1;
    eor_at = -1; cs_low = 0; rises = 0; hi_min = 1000; hi_max = 0; eors = 0;
    hi_run = 0; prev_d = 1'b0; dat = 12'h000; busy0 = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (n == 0) begin
        bus.strr_i = 1'b0;
        busy0 = bus.busy_o;
      end else if (n == poke_at) begin
        bus.strr_i = 1'b1;
        bus.kmax_i = 8'd7;
      end else if (n == poke_at + 1) begin
        bus.strr_i = 1'b0;
      end
      if (!bus.cs_o) cs_low++;
      if (bus.dclk_o) begin
        if (!prev_d) rises++;
        hi_run++;
      end else if (prev_d) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        hi_run = 0;
      end
      prev_d = bus.dclk_o;
      if (bus.eor_o) begin
        eors++;
        if (eor_at < 0) begin
          eor_at = n;
          dat = bus.data_o;
        end
      end
      if (eor_at >= 0 && n >= eor_at + 4) break;
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.strr_i = 1'b1;
    bus.kmax_i = 8'd3;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total += 5;
      if (bus.cs_o !== 1'b1) $display("FAIL reset_cs cycle %0d got %b exp 1", c, bus.cs_o); else passed++;
      if (bus.dclk_o !== 1'b0) $display("FAIL reset_dclk cycle %0d got %b exp 0", c, bus.dclk_o); else passed++;
      if (bus.data_o !== 12'h000) $display("FAIL reset_data cycle %0d got %h exp 000", c, bus.data_o); else passed++;
      if (bus.eor_o !== 1'b0) $display("FAIL reset_eor cycle %0d got %b exp 0", c, bus.eor_o); else passed++;
      if (bus.busy_o !== 1'b0) $display("FAIL reset_busy cycle %0d got %b exp 0", c, bus.busy_o); else passed++;
    end
    @(negedge clk);
    rst_n      = 1'b1;
    bus.strr_i = 1'b0;
  endtask

  task automatic test_nominal();
    int eor_at, cs_low, rises, hi_min, hi_max, eors;
    logic [11:0] dat;
    logic busy0;
    run_frame(8'd3, 12'hA5C, -10, eor_at, cs_low, rises, hi_min, hi_max, eors, dat, busy0);
    total += 9;
    if (busy0 !== 1'b1) $display("FAIL nom_busy got %b exp 1", busy0); else passed++;
    if (eor_at != 100) $display("FAIL nom_eor_time got %0d exp 100", eor_at); else passed++;
    if (cs_low != 100) $display("FAIL nom_cs_low got %0d exp 100", cs_low); else passed++;
    if (rises != 12) $display("FAIL nom_rises got %0d exp 12", rises); else passed++;
    if (hi_min != 4) $display("FAIL nom_hi_min got %0d exp 4", hi_min); else passed++;
    if (hi_max != 4) $display("FAIL nom_hi_max got %0d exp 4", hi_max); else passed++;
    if (eors != 1) $display("FAIL nom_eor_count got %0d exp 1", eors); else passed++;
    if (dat !== 12'hA5C) $display("FAIL nom_data got %h exp a5c", dat); else passed++;
    if (bus.data_o !== 12'hA5C) $display("FAIL nom_data_hold got %h exp a5c", bus.data_o); else passed++;
  endtask

  task automatic test_fastest();
    int eor_at, cs_low, rises, hi_min, hi_max, eors;
    logic [11:0] dat;
    logic busy0;
    logic [11:0] pats [0:2];
    pats[0] = 12'h801;
    pats[1] = 12'hFFF;
    pats[2] = 12'h000;
    for (int p = 0; p < 3; p++) begin
      run_frame(8'd0, pats[p], -10, eor_at, cs_low, rises, hi_min, hi_max, eors, dat, busy0);
      total += 4;
      if (eor_at != 25) $display("FAIL fast_eor_time pat %h got %0d exp 25", pats[p], eor_at); else passed++;
      if (rises != 12) $display("FAIL fast_rises pat %h got %0d exp 12", pats[p], rises); else passed++;
      if (hi_max != 1) $display("FAIL fast_hi_max pat %h got %0d exp 1", pats[p], hi_max); else passed++;
      if (dat !== pats[p]) $display("FAIL fast_data got %h exp %h", dat, pats[p]); else passed++;
    end
  endtask

  task automatic test_busy_lock();
    int eor_at, cs_low, rises, hi_min, hi_max, eors;
    logic [11:0] dat;
    logic busy0;
    run_frame(8'd3, 12'h6B3, 30, eor_at, cs_low, rises, hi_min, hi_max, eors, dat, busy0);
    total += 5;
    if (eor_at != 100) $display("FAIL lock_eor_time got %0d exp 100", eor_at); else passed++;
    if (cs_low != 100) $display("FAIL lock_cs_low got %0d exp 100", cs_low); else passed++;
    if (hi_max != 4) $display("FAIL lock_hi_max got %0d exp 4", hi_max); else passed++;
    if (eors != 1) $display("FAIL lock_eor_count got %0d exp 1", eors); else passed++;
    if (dat !== 12'h6B3) $display("FAIL lock_data got %h exp 6b3", dat); else passed++;
  endtask

  task automatic test_reset_mid();
    int   rises, eor_seen, eor_at, cs_low, hi_min, hi_max, eors;
    logic prev_d;
    logic [11:0] dat;
    logic busy0;
    @(negedge clk);
    word_base    = frames_seen;
    adc_words[0] = 12'h5A5;
    adc_words[1] = 12'h5A5;
    bus.kmax_i   = 8'd3;
    bus.strr_i   = 1'b1;
    rises = 0; prev_d = 1'b0; eor_seen = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      bus.strr_i = 1'b0;
      if (bus.dclk_o && !prev_d) rises++;
      prev_d = bus.dclk_o;
      if (rises == 5) break;
    end
    total += 1;
    if (rises != 5) $display("FAIL rmid_reach_5th got %0d exp 5", rises); else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    total += 5;
    if (bus.cs_o !== 1'b1) $display("FAIL rmid_cs got %b exp 1", bus.cs_o); else passed++;
    if (bus.dclk_o !== 1'b0) $display("FAIL rmid_dclk got %b exp 0", bus.dclk_o); else passed++;
    if (bus.data_o !== 12'h000) $display("FAIL rmid_data got %h exp 000", bus.data_o); else passed++;
    if (bus.eor_o !== 1'b0) $display("FAIL rmid_eor got %b exp 0", bus.eor_o); else passed++;
    if (bus.busy_o !== 1'b0) $display("FAIL rmid_busy got %b exp 0", bus.busy_o); else passed++;
    rst_n = 1'b1;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      if (bus.eor_o) eor_seen++;
    end
    total += 1;
    if (eor_seen != 0) $display("FAIL rmid_no_eor got %0d exp 0", eor_seen); else passed++;
    run_frame(8'd3, 12'h3C6, -10, eor_at, cs_low, rises, hi_min, hi_max, eors, dat, busy0);
    total += 2;
    if (eor_at != 100) $display("FAIL rmid_restart_time got %0d exp 100", eor_at); else passed++;
    if (dat !== 12'h3C6) $display("FAIL rmid_restart_data got %h exp 3c6", dat); else passed++;
  endtask

  task automatic test_back_to_back();
    int   e1, e2, cs_hi, phase;
    logic [11:0] d1, d2;
    @(negedge clk);
    word_base    = frames_seen;
    adc_words[0] = 12'h123;
    adc_words[1] = 12'hEDC;
    bus.kmax_i   = 8'd1;
    bus.strr_i   = 1'b1;
    e1 = -1; e2 = -1; cs_hi = 0; phase = 0; d1 = 12'h000; d2 = 12'h000;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (phase == 1 && bus.cs_o) cs_hi++;
      if (phase == 1 && !bus.cs_o) begin
        phase = 2;
        bus.strr_i = 1'b0;
      end
      if (bus.eor_o) begin
        if (e1 < 0) begin
          e1 = n; d1 = bus.data_o; phase = 1;
          cs_hi = bus.cs_o ? 1 : 0;
        end else if (e2 < 0) begin
          e2 = n; d2 = bus.data_o;
        end
      end
      if (e2 >= 0) break;
    end
    bus.strr_i = 1'b0;
    total += 5;
    if (e1 != 50) $display("FAIL b2b_eor1_time got %0d exp 50", e1); else passed++;
    if (e2 != 101) $display("FAIL b2b_eor2_time got %0d exp 101", e2); else passed++;
    if (cs_hi != 1) $display("FAIL b2b_cs_gap got %0d exp 1", cs_hi); else passed++;
    if (d1 !== 12'h123) $display("FAIL b2b_data1 got %h exp 123", d1); else passed++;
    if (d2 !== 12'hEDC) $display("FAIL b2b_data2 got %h exp edc", d2); else passed++;
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    word_base    = 0;
    adc_words[0] = 12'h000;
    adc_words[1] = 12'h000;
    rst_n        = 1'b0;
    bus.strr_i   = 1'b0;
    bus.kmax_i   = 8'd0;
    test_reset();
    test_nominal();
    test_fastest();
    test_busy_lock();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_read_adc.md
Name: spi_read_adc

Overview:
- SPI read stage for the ADC path. It sits directly downstream of the ADC command writer.
- After a command frame completes, the sequencer pulses strr_i. This block lowers cs_o, generates dclk_o from a programmable divider, and shifts DATA_W bits in from miso_i, MSB first.
- When the frame is done it presents the word on data_o with a one-cycle eor_o pulse.
- Mode: SPI mode 0. dclk_o idles low. The ADC changes miso on the falling edge; this block samples at the rising edge.

Parameters:
- DATA_W, 12, number of bits read per frame (range 2..16).
- KW, 8, width of kmax_i and of the divider counter.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-low reset.
- strr_i  input  1  start-read request; sampled only in IDLE.
- kmax_i  input  KW  half-period control. One dclk half-period is (kmax+1) clk_i cycles. Latched at start.
- miso_i  input  1  serial data from the ADC.
- cs_o  output  1  chip select, active low.
- dclk_o  output  1  serial clock to the ADC.
- data_o  output  DATA_W  last completed word; held until the next frame completes.
- eor_o  output  1  end-of-read; one-cycle pulse when data_o updates.
- busy_o  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst_i=0 at an edge):
  - state=IDLE, cs_o=1, dclk_o=0, data_o=0, eor_o=0, busy_o=0.
  - Divider, bit counter and shift register cleared.
  - Reset mid-frame aborts the frame: no eor_o, data_o=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Divider:
  - Counter cnt runs 0..kmax_q. tick=1 when cnt==kmax_q, then cnt wraps to 0.
  - cnt is cleared on every state change and is held at 0 in IDLE.
  - kmax_q is latched from kmax_i on frame start. Changes to kmax_i mid-frame are ignored.
  - kmax_q=0 gives tick every cycle (dclk half-period = 1 clk).
- FSM states:
  - IDLE: cs_o=1, dclk_o=0. If strr_i=1: latch kmax_q, clear bit count and shift register, go to SETUP.
  - SETUP: cs_o=0, dclk_o=0. On tick: shift in miso_i (shreg <= {shreg[DATA_W-2:0], miso_i}), go to HIGH. This edge sets dclk_o=1.
  - HIGH: dclk_o=1. On tick: if bitcnt==DATA_W-1, go to HOLD; otherwise bitcnt+1 and go to LOW. dclk_o falls on this edge.
  - LOW: dclk_o=0. On tick: shift in miso_i, go to HIGH.
  - HOLD: cs_o=0, dclk_o=0 (CS hold time). On tick: data_o <= shreg, eor_o=1 for one cycle, cs_o=1, go to IDLE.
- Frame timing:
  - Exactly DATA_W rising dclk edges per frame; each miso sample coincides with a rising dclk edge.
  - Frame length is 2*DATA_W+1 half-periods.
  - If strr_i is sampled high at edge E0, cs_o falls at E0 and eor_o rises at E0+(2*DATA_W+1)*(kmax+1).
- Busy and back-to-back:
  - strr_i is ignored while busy_o=1.
  - The eor_o cycle is spent in IDLE. strr_i high during that cycle starts the next frame at the following edge, so cs_o is high for a minimum of 1 cycle between frames.
- bitcnt width is ceil(log2(DATA_W)). No wrap beyond DATA_W-1.

Test Plan:
- Reset: hold rst_i=0 for 3 cycles with strr_i=1 -> cs_o=1, dclk_o=0, data_o=0, eor_o=0, busy_o=0 throughout.
- Nominal read: kmax_i=3, ADC model drives 0xA5C MSB-first, changing on dclk falling edges -> 12 dclk rising edges, each high 4 clk; cs_o low for exactly 100 cycles; eor_o pulse at E0+100; data_o=0xA5C.
- Fastest clock: kmax_i=0, pattern 0x801 -> dclk toggles every clk; eor_o at E0+25; data_o=0x801. Repeat with 0xFFF and 0x000.
- Busy and parameter lock: start with kmax_i=3, then pulse strr_i and change kmax_i to 7 mid-frame -> frame unaffected (100 cycles, single eor_o); data_o correct.
- Reset mid-frame: assert rst_i=0 after the 5th dclk rising edge -> next edge cs_o=1, dclk_o=0, data_o=0; no eor_o; a subsequent start reads correctly.
- Back-to-back: hold strr_i=1 over two frames with words 0x123 then 0xEDC -> cs_o high exactly 1 cycle between frames; two eor_o pulses; data_o=0x123 then 0xEDC.
